// File: rtl/texture_spi_fetch.sv
// SPI flash burst reader for texture ROM fetches: command, address, optional
// dummy clocks, then (req_len+1) words shifted in over 1, 2 or 4 IO lanes.
module texture_spi_fetch #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LEN_W     = 6,
  parameter int unsigned HALF_DIV  = 1,
  parameter int unsigned DUMMY_CYC = 8,
  parameter int unsigned CSB_IDLE  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              spi_csb,
  output logic              spi_sclk,
  output logic [3:0]        spi_io_out,
  output logic [3:0]        spi_io_oe,
  input  logic [3:0]        spi_io_in
);

  localparam int unsigned CMD_W   = 8;
  localparam int unsigned SR_W    = CMD_W + ADDR_W;
  localparam int unsigned MAX_A   = (ADDR_W > CMD_W) ? ADDR_W : CMD_W;
  localparam int unsigned MAX_B   = (DUMMY_CYC > DATA_W) ? DUMMY_CYC : DATA_W;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DIV_W   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned GAP_W   = (CSB_IDLE > 1) ? $clog2(CSB_IDLE) : 1;
  localparam int unsigned DUM_L   = (DUMMY_CYC > 0) ? DUMMY_CYC - 1 : 0;

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DUM_LAST  = CNT_W'(DUM_L);
  localparam logic [CNT_W-1:0] W1_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] W2_LAST   = CNT_W'(DATA_W / 2 - 1);
  localparam logic [CNT_W-1:0] W4_LAST   = CNT_W'(DATA_W / 4 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CSB_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    word_q, word_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                sclk_q, sclk_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [DATA_W-1:0]   in_q, in_d;
  logic                done_q, done_d;
  logic                wlast_q, wlast_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                fall;
  logic                dual, quad;
  logic [CNT_W-1:0]    word_bits_last;
  logic                rx_phase;

  function automatic logic [CMD_W-1:0] cmd_for(input logic [1:0] m);
    case (m)
      2'd1:    return 8'h3B;
      2'd2:    return 8'h6B;
      default: return 8'h03;
    endcase
  endfunction

  assign dual = (mode_q == 2'd1);
  assign quad = (mode_q == 2'd2);
  assign word_bits_last = quad ? W4_LAST : (dual ? W2_LAST : W1_LAST);

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      len_q      <= '0;
      word_q     <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      gap_q      <= '0;
      sclk_q     <= 1'b0;
      sr_q       <= '0;
      in_q       <= '0;
      done_q     <= 1'b0;
      wlast_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      sclk_q     <= sclk_d;
      sr_q       <= sr_d;
      in_q       <= in_d;
      done_q     <= done_d;
      wlast_q    <= wlast_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next-state: SCLK divider, phase sequencing, shifting and word handoff
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    word_d     = word_q;
    bit_d      = bit_q;
    div_d      = div_q;
    gap_d      = gap_q;
    sclk_d     = sclk_q;
    sr_d       = sr_q;
    in_d       = in_q;
    done_d     = 1'b0;
    wlast_d    = wlast_q;
    rd_valid_d = done_q;
    rd_last_d  = done_q & wlast_q;
    rd_data_d  = done_q ? in_q : rd_data_q;
    fall       = 1'b0;

    if (state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA}) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        fall   = sclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_CMD;
          mode_d  = mode;
          len_d   = req_len;
          word_d  = '0;
          bit_d   = '0;
          div_d   = '0;
          sclk_d  = 1'b0;
          sr_d    = {cmd_for(mode), req_addr};
        end
      end
      S_CMD: begin
        if (fall) begin
          sr_d = sr_q << 1;
          if (bit_q == CMD_LAST) begin
            bit_d   = '0;
            state_d = S_ADDR;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (fall) begin
          sr_d = sr_q << 1;
          if (bit_q == ADDR_LAST) begin
            bit_d   = '0;
            state_d = ((dual || quad) && DUMMY_CYC > 0) ? S_DUMMY : S_DATA;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_DUMMY: begin
        if (fall) begin
          if (bit_q == DUM_LAST) begin
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          // Single-lane reads arrive on io1; dual puts the earlier bit on io1.
          if (quad)      in_d = DATA_W'({in_q, spi_io_in[3:0]});
          else if (dual) in_d = DATA_W'({in_q, spi_io_in[1:0]});
          else           in_d = DATA_W'({in_q, spi_io_in[1]});
          if (bit_q == word_bits_last) begin
            bit_d   = '0;
            done_d  = 1'b1;
            wlast_d = (word_q == len_q);
            if (word_q == len_q) state_d = S_DONE;
            else                 word_d  = word_q + 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      // SCLK is parked low; CS stays asserted until the last word is handed off.
      S_DONE: begin
        if (rd_valid_q && rd_last_q) begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin drive derived from registered state so pins move only on clk edges
  always_comb begin
    rx_phase   = state_q inside {S_DUMMY, S_DATA, S_DONE};
    spi_io_out = 4'b1100;
    spi_io_oe  = 4'b1101;
    if (state_q inside {S_CMD, S_ADDR}) spi_io_out[0] = sr_q[SR_W-1];
    if (rx_phase && (dual || quad))     spi_io_oe[0]   = 1'b0;
    if (rx_phase && quad)               spi_io_oe[3:2] = 2'b00;
  end

  assign spi_csb   = !(state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE});
  assign spi_sclk  = sclk_q;
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;

endmodule
